mr_ex: RTL

//  Execute stage: takes one decoded op per handshake from decode, computes the ALU result or memory

---
 rtl/mr_pkg.sv | 52 +++++
 rtl/mr_shift_iter.sv | 54 +++++
 rtl/mr_ex.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mr_pkg.sv
// Shared types and widths for the mr execute stage and its iterative shifter.
package mr_pkg;

    localparam int XLEN        = 32;
    localparam int SHAMT_BITS  = 5;
    localparam int ALU_OP_BITS = 4;
    localparam int MEM_OP_BITS = 2;
    localparam int MEM_SZ_BITS = 2;
    localparam int REGSEL_BITS = 5;

    localparam logic [MEM_OP_BITS-1:0] MEMOP_NONE  = 2'd0;
    localparam logic [MEM_OP_BITS-1:0] MEMOP_LOAD  = 2'd1;
    localparam logic [MEM_OP_BITS-1:0] MEMOP_STORE = 2'd2;

    typedef enum logic [ALU_OP_BITS-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_PASSB = 4'd7,
        ALU_SLL   = 4'd8,
        ALU_SRL   = 4'd9,
        ALU_SRA   = 4'd10
    } alu_op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ex_state_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_kind_e;

    function automatic logic is_shift_op(input alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

    function automatic shift_kind_e to_shift_kind(input alu_op_e op);
        case (op)
            ALU_SRL: return SH_SRL;
            ALU_SRA: return SH_SRA;
            default: return SH_SLL;
        endcase
    endfunction

endpackage

// File: rtl/mr_shift_iter.sv
// One-bit-per-cycle shifter: loaded on start, steps while active, and freezes on its
// last step if the consumer cannot take the result yet.
module mr_shift_iter
    import mr_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  active,
    input  logic                  stall,
    input  shift_kind_e           kind_i,
    input  logic [XLEN-1:0]       op_a_i,
    input  logic [SHAMT_BITS-1:0] shamt_i,
    output logic                  done_o,
    output logic [XLEN-1:0]       result_o
);

    logic [XLEN-1:0]       acc_q;
    logic [SHAMT_BITS-1:0] cnt_q;
    shift_kind_e           kind_q;
    logic [XLEN-1:0]       step;
    logic                  last;

    always_comb begin
        step = acc_q;
        case (kind_q)
            SH_SLL:  step = acc_q << 1;
            SH_SRL:  step = acc_q >> 1;
            SH_SRA:  step = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
            default: step = acc_q;
        endcase
    end

    assign last     = (cnt_q == SHAMT_BITS'(1));
    assign done_o   = active && last && !stall;
    assign result_o = step;

    // The final step is held back while stalled so the finished value is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            kind_q <= SH_SLL;
        end else if (start) begin
            acc_q  <= op_a_i;
            cnt_q  <= shamt_i;
            kind_q <= kind_i;
        end else if (active && !(last && stall)) begin
            acc_q <= step;
            cnt_q <= cnt_q - SHAMT_BITS'(1);
        end
    end

endmodule

// File: rtl/mr_ex.sv
// Execute stage: ALU / address generation, shift sequencing FSM and one registered
// output slot toward mr_ldst.
module mr_ex
    import mr_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   de_valid_i,
    output logic                   de_ready_o,
    input  alu_op_e                de_alu_op_i,
    input  logic [XLEN-1:0]        de_op_a_i,
    input  logic [XLEN-1:0]        de_op_b_i,
    input  logic [MEM_OP_BITS-1:0] de_mem_op_i,
    input  logic [MEM_SZ_BITS-1:0] de_mem_size_i,
    input  logic                   de_signed_i,
    input  logic [XLEN-1:0]        de_store_i,
    input  logic [REGSEL_BITS-1:0] de_dst_reg_i,
    output logic [MEM_OP_BITS-1:0] ex_op_o,
    output logic [MEM_SZ_BITS-1:0] ex_size_o,
    output logic                   ex_signed_o,
    output logic [XLEN-1:0]        ex_addr_o,
    output logic [XLEN-1:0]        ex_payload_o,
    output logic [REGSEL_BITS-1:0] ex_dst_reg_o,
    output logic                   ex_valid_o,
    input  logic                   ex_ready_i,
    output ex_state_e              dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and the slot holds its data while valid && !ready.

    ex_state_e             state_q, state_d;
    logic                  slot_free;
    logic                  accept;
    logic                  shift_op;
    logic [SHAMT_BITS-1:0] shamt;
    logic                  start_shift;
    logic                  load_direct;
    logic                  sh_done;
    logic [XLEN-1:0]       sh_result;
    logic [XLEN-1:0]       alu_res;
    logic [REGSEL_BITS-1:0] sh_dst_q;

    assign slot_free   = !ex_valid_o || ex_ready_i;
    assign de_ready_o  = (state_q == IDLE) && slot_free;
    assign accept      = de_valid_i && de_ready_o;
    assign shift_op    = (de_mem_op_i == MEMOP_NONE) && is_shift_op(de_alu_op_i);
    assign shamt       = de_op_b_i[SHAMT_BITS-1:0];
    assign start_shift = accept && shift_op && (shamt != '0);
    assign load_direct = accept && !start_shift;
    assign dbg_state_o = state_q;

    // Memory ops always add; shifts report op_a here, used only for a zero shift amount.
    always_comb begin
        alu_res = '0;
        if (de_mem_op_i != MEMOP_NONE) begin
            alu_res = de_op_a_i + de_op_b_i;
        end else begin
            case (de_alu_op_i)
                ALU_ADD:   alu_res = de_op_a_i + de_op_b_i;
                ALU_SUB:   alu_res = de_op_a_i - de_op_b_i;
                ALU_AND:   alu_res = de_op_a_i & de_op_b_i;
                ALU_OR:    alu_res = de_op_a_i | de_op_b_i;
                ALU_XOR:   alu_res = de_op_a_i ^ de_op_b_i;
                ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(de_op_a_i) < $signed(de_op_b_i))};
                ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (de_op_a_i < de_op_b_i)};
                ALU_PASSB: alu_res = de_op_b_i;
                ALU_SLL, ALU_SRL, ALU_SRA: alu_res = de_op_a_i;
                default:   alu_res = '0;
            endcase
        end
    end

    mr_shift_iter u_shift (
        .clk      (clk),
        .rst      (rst),
        .start    (start_shift),
        .active   (state_q == SHIFT),
        .stall    (!slot_free),
        .kind_i   (to_shift_kind(de_alu_op_i)),
        .op_a_i   (de_op_a_i),
        .shamt_i  (shamt),
        .done_o   (sh_done),
        .result_o (sh_result)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_shift) state_d = SHIFT;
            SHIFT:   if (sh_done)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            sh_dst_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_shift) sh_dst_q <= de_dst_reg_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_o   <= 1'b0;
            ex_op_o      <= '0;
            ex_size_o    <= '0;
            ex_signed_o  <= 1'b0;
            ex_addr_o    <= '0;
            ex_payload_o <= '0;
            ex_dst_reg_o <= '0;
        end else if (load_direct) begin
            ex_valid_o   <= 1'b1;
            ex_op_o      <= de_mem_op_i;
            ex_size_o    <= de_mem_size_i;
            ex_signed_o  <= de_signed_i;
            ex_addr_o    <= alu_res;
            ex_payload_o <= (de_mem_op_i != MEMOP_NONE) ? de_store_i : '0;
            ex_dst_reg_o <= de_dst_reg_i;
        end else if (sh_done) begin
            ex_valid_o   <= 1'b1;
            ex_op_o      <= MEMOP_NONE;
            ex_size_o    <= '0;
            ex_signed_o  <= 1'b0;
            ex_addr_o    <= sh_result;
            ex_payload_o <= '0;
            ex_dst_reg_o <= sh_dst_q;
        end else if (ex_ready_i) begin
            ex_valid_o <= 1'b0;
        end
    end

endmodule
